// File: rtl/aes_pkg.sv
// -----------------------------------------------------------------------------
// aes_pkg
// Shared definitions for the iterative AES-128 decryption core:
//   - aes_state_e     : controller state encoding
//   - SBOX / INV_SBOX : forward and inverse AES S-boxes
//   - RCON            : round constants, RCON[1..10] used (RCON[0] unused)
//   - gf_xtime, gf_mul, inv_shift_rows, inv_sub_bytes, inv_mix_columns
// State layout: 128-bit vector, byte i at [127-8*i -: 8], byte i = 4*col + row.
// -----------------------------------------------------------------------------
package aes_pkg;

  typedef enum logic [2:0] {
    ST_IDLE, ST_KEYEXP, ST_ARK_INIT, ST_ISR, ST_ISB, ST_ARK, ST_IMC, ST_DONE
  } aes_state_e;

  localparam logic [7:0] SBOX [256] = '{
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
    8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
    8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
    8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
    8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
    8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
    8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
    8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
    8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
    8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
    8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
    8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
    8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
    8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
    8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
    8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
  };

  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52,8'h09,8'h6a,8'hd5,8'h30,8'h36,8'ha5,8'h38,8'hbf,8'h40,8'ha3,8'h9e,8'h81,8'hf3,8'hd7,8'hfb,
    8'h7c,8'he3,8'h39,8'h82,8'h9b,8'h2f,8'hff,8'h87,8'h34,8'h8e,8'h43,8'h44,8'hc4,8'hde,8'he9,8'hcb,
    8'h54,8'h7b,8'h94,8'h32,8'ha6,8'hc2,8'h23,8'h3d,8'hee,8'h4c,8'h95,8'h0b,8'h42,8'hfa,8'hc3,8'h4e,
    8'h08,8'h2e,8'ha1,8'h66,8'h28,8'hd9,8'h24,8'hb2,8'h76,8'h5b,8'ha2,8'h49,8'h6d,8'h8b,8'hd1,8'h25,
    8'h72,8'hf8,8'hf6,8'h64,8'h86,8'h68,8'h98,8'h16,8'hd4,8'ha4,8'h5c,8'hcc,8'h5d,8'h65,8'hb6,8'h92,
    8'h6c,8'h70,8'h48,8'h50,8'hfd,8'hed,8'hb9,8'hda,8'h5e,8'h15,8'h46,8'h57,8'ha7,8'h8d,8'h9d,8'h84,
    8'h90,8'hd8,8'hab,8'h00,8'h8c,8'hbc,8'hd3,8'h0a,8'hf7,8'he4,8'h58,8'h05,8'hb8,8'hb3,8'h45,8'h06,
    8'hd0,8'h2c,8'h1e,8'h8f,8'hca,8'h3f,8'h0f,8'h02,8'hc1,8'haf,8'hbd,8'h03,8'h01,8'h13,8'h8a,8'h6b,
    8'h3a,8'h91,8'h11,8'h41,8'h4f,8'h67,8'hdc,8'hea,8'h97,8'hf2,8'hcf,8'hce,8'hf0,8'hb4,8'he6,8'h73,
    8'h96,8'hac,8'h74,8'h22,8'he7,8'had,8'h35,8'h85,8'he2,8'hf9,8'h37,8'he8,8'h1c,8'h75,8'hdf,8'h6e,
    8'h47,8'hf1,8'h1a,8'h71,8'h1d,8'h29,8'hc5,8'h89,8'h6f,8'hb7,8'h62,8'h0e,8'haa,8'h18,8'hbe,8'h1b,
    8'hfc,8'h56,8'h3e,8'h4b,8'hc6,8'hd2,8'h79,8'h20,8'h9a,8'hdb,8'hc0,8'hfe,8'h78,8'hcd,8'h5a,8'hf4,
    8'h1f,8'hdd,8'ha8,8'h33,8'h88,8'h07,8'hc7,8'h31,8'hb1,8'h12,8'h10,8'h59,8'h27,8'h80,8'hec,8'h5f,
    8'h60,8'h51,8'h7f,8'ha9,8'h19,8'hb5,8'h4a,8'h0d,8'h2d,8'he5,8'h7a,8'h9f,8'h93,8'hc9,8'h9c,8'hef,
    8'ha0,8'he0,8'h3b,8'h4d,8'hae,8'h2a,8'hf5,8'hb0,8'hc8,8'heb,8'hbb,8'h3c,8'h83,8'h53,8'h99,8'h61,
    8'h17,8'h2b,8'h04,8'h7e,8'hba,8'h77,8'hd6,8'h26,8'he1,8'h69,8'h14,8'h63,8'h55,8'h21,8'h0c,8'h7d
  };

  localparam logic [7:0] RCON [11] = '{
    8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  // Multiply by x modulo x^8+x^4+x^3+x+1 (0x11B).
  function automatic logic [7:0] gf_xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Multiply by one of the InvMixColumns constants 9, 11, 13, 14.
  function automatic logic [7:0] gf_mul(input logic [7:0] b, input logic [3:0] m);
    logic [7:0] x2, x4, x8, r;
    x2 = gf_xtime(b);
    x4 = gf_xtime(x2);
    x8 = gf_xtime(x4);
    case (m)
      4'd9:    r = x8 ^ b;
      4'd11:   r = x8 ^ x2 ^ b;
      4'd13:   r = x8 ^ x4 ^ b;
      4'd14:   r = x8 ^ x4 ^ x2;
      default: r = b;
    endcase
    return r;
  endfunction

  // Row r rotates right by r: out(row,col) = in(row,(col-row) mod 4).
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int i = 0; i < 16; i++)
      o[127-8*i -: 8] = INV_SBOX[s[127-8*i -: 8]];
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = gf_mul(a0,4'd14) ^ gf_mul(a1,4'd11) ^ gf_mul(a2,4'd13) ^ gf_mul(a3,4'd9);
      o[119-32*c -: 8] = gf_mul(a0,4'd9)  ^ gf_mul(a1,4'd14) ^ gf_mul(a2,4'd11) ^ gf_mul(a3,4'd13);
      o[111-32*c -: 8] = gf_mul(a0,4'd13) ^ gf_mul(a1,4'd9)  ^ gf_mul(a2,4'd14) ^ gf_mul(a3,4'd11);
      o[103-32*c -: 8] = gf_mul(a0,4'd11) ^ gf_mul(a1,4'd13) ^ gf_mul(a2,4'd9)  ^ gf_mul(a3,4'd14);
    end
    return o;
  endfunction

endpackage

// File: rtl/aes_decrypt_core_if.sv
// -----------------------------------------------------------------------------
// aes_decrypt_core_if
// Connection between the AES register file (master) and the decryption core
// (slave).
//   AES_START   : start request, level-sensitive (register file -> core)
//   AES_KEY     : 128-bit cipher key, [127:96] = key word 0
//   AES_MSG_ENC : 128-bit ciphertext, [127:120] = state byte 0
//   AES_MSG_DEC : 128-bit plaintext result (core -> register file)
//   AES_DONE    : result valid (core -> register file)
// -----------------------------------------------------------------------------
interface aes_decrypt_core_if;
  logic         AES_START;
  logic [127:0] AES_KEY;
  logic [127:0] AES_MSG_ENC;
  logic [127:0] AES_MSG_DEC;
  logic         AES_DONE;

  modport master (output AES_START, AES_KEY, AES_MSG_ENC, input AES_MSG_DEC, AES_DONE);
  modport slave  (input AES_START, AES_KEY, AES_MSG_ENC, output AES_MSG_DEC, AES_DONE);
endinterface

// File: rtl/aes_key_round.sv
// -----------------------------------------------------------------------------
// aes_key_round
// Combinational AES-128 key-schedule step: next round key from previous one.
//   i_rk   : previous round key, [127:96] = word 0
//   i_rcon : round constant for this step
//   o_rk   : next round key
// -----------------------------------------------------------------------------
module aes_key_round
  import aes_pkg::*;
(
  input  logic [127:0] i_rk,
  input  logic [7:0]   i_rcon,
  output logic [127:0] o_rk
);

  logic [31:0] w_w0, w_w1, w_w2, w_w3, w_t, w_n0, w_n1, w_n2, w_n3;

  assign {w_w0, w_w1, w_w2, w_w3} = i_rk;

  // SubWord(RotWord(w3)) with rcon folded into the top byte
  assign w_t = {SBOX[w_w3[23:16]] ^ i_rcon, SBOX[w_w3[15:8]],
                SBOX[w_w3[7:0]], SBOX[w_w3[31:24]]};

  assign w_n0 = w_w0 ^ w_t;
  assign w_n1 = w_w1 ^ w_n0;
  assign w_n2 = w_w2 ^ w_n1;
  assign w_n3 = w_w3 ^ w_n2;
  assign o_rk = {w_n0, w_n1, w_n2, w_n3};

endmodule

// File: rtl/aes_decrypt_core.sv
// -----------------------------------------------------------------------------
// aes_decrypt_core
// Iterative AES-128 decryption, one primitive operation per clock. Round keys
// are expanded on the fly into r_rk[0..10], then the rounds run in reverse.
//   CLK    : system clock
//   RESET  : asynchronous active-low reset
//   aes_if : slave side of aes_decrypt_core_if (start/key/ciphertext in,
//            plaintext/done out)
// Optional: `define AES_KEY_CACHE_EN keeps the last fully expanded key; a start
// with the same key skips key expansion (40 edges instead of 50).
// -----------------------------------------------------------------------------
module aes_decrypt_core
  import aes_pkg::*;
#(
  parameter int N_ROUNDS = 10
)(
  input  logic              CLK,
  input  logic              RESET,
  aes_decrypt_core_if.slave aes_if
);

  if (N_ROUNDS != 10) begin : g_bad_rounds
    $error("aes_decrypt_core: only N_ROUNDS = 10 is supported");
  end

  aes_state_e   r_state, w_next;
  logic [3:0]   r_cnt;
  logic [127:0] r_dat, r_msg_dec;
  logic         r_done;
  logic [127:0] r_rk [0:N_ROUNDS];
  logic [127:0] w_rk_next, w_ark;
  logic         w_start, w_hit;

  assign w_start = aes_if.AES_START;
  assign w_ark   = r_dat ^ r_rk[r_cnt];

  assign aes_if.AES_MSG_DEC = r_msg_dec;
  assign aes_if.AES_DONE    = r_done;

  aes_key_round u_key_round (
    .i_rk   (r_rk[r_cnt - 4'd1]),
    .i_rcon (RCON[r_cnt]),
    .o_rk   (w_rk_next)
  );

`ifdef AES_KEY_CACHE_EN
  logic [127:0] r_cache_key;
  logic         r_cache_vld;

  assign w_hit = r_cache_vld && (aes_if.AES_KEY == r_cache_key);

  // Invalidate as soon as a new expansion starts overwriting r_rk, so an
  // aborted expansion can never be mistaken for a valid schedule.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_cache_key <= '0;
      r_cache_vld <= 1'b0;
    end else if (r_state == ST_IDLE && w_start && !w_hit) begin
      r_cache_vld <= 1'b0;
    end else if (r_state == ST_KEYEXP && w_start && r_cnt == 4'(N_ROUNDS)) begin
      r_cache_key <= r_rk[0];
      r_cache_vld <= 1'b1;
    end
  end
`else
  assign w_hit = 1'b0;
`endif

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:     if (w_start) w_next = w_hit ? ST_ARK_INIT : ST_KEYEXP;
      ST_KEYEXP:   if (r_cnt == 4'(N_ROUNDS)) w_next = ST_ARK_INIT;
      ST_ARK_INIT: w_next = ST_ISR;
      ST_ISR:      w_next = ST_ISB;
      ST_ISB:      w_next = ST_ARK;
      ST_ARK:      w_next = (r_cnt == 4'd0) ? ST_DONE : ST_IMC;
      ST_IMC:      w_next = ST_ISR;
      ST_DONE:     if (!w_start) w_next = ST_IDLE;
      default:     w_next = ST_IDLE;
    endcase
    // Dropping start while busy abandons the run
    if (!w_start && r_state != ST_IDLE && r_state != ST_DONE) w_next = ST_IDLE;
  end

  // Datapath only advances while start is held, so an abort leaves the
  // outputs exactly as they were.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_cnt     <= '0;
      r_dat     <= '0;
      r_msg_dec <= '0;
      r_done    <= 1'b0;
      for (int i = 0; i <= N_ROUNDS; i++) r_rk[i] <= '0;
    end else begin
      case (r_state)
        ST_IDLE: if (w_start) begin
          r_rk[0] <= aes_if.AES_KEY;
          r_dat   <= aes_if.AES_MSG_ENC;
          r_cnt   <= 4'd1;
        end
        ST_KEYEXP: if (w_start) begin
          r_rk[r_cnt] <= w_rk_next;
          r_cnt       <= r_cnt + 4'd1;
        end
        ST_ARK_INIT: if (w_start) begin
          r_dat <= r_dat ^ r_rk[N_ROUNDS];
          r_cnt <= 4'(N_ROUNDS - 1);
        end
        ST_ISR: if (w_start) r_dat <= inv_shift_rows(r_dat);
        ST_ISB: if (w_start) r_dat <= inv_sub_bytes(r_dat);
        ST_ARK: if (w_start) begin
          r_dat <= w_ark;
          if (r_cnt == 4'd0) begin
            r_msg_dec <= w_ark;
            r_done    <= 1'b1;
          end
        end
        ST_IMC: if (w_start) begin
          r_dat <= inv_mix_columns(r_dat);
          r_cnt <= r_cnt - 4'd1;
        end
        ST_DONE: if (!w_start) r_done <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_decrypt_core.sv
// -----------------------------------------------------------------------------
// tb_aes_decrypt_core
// Self-checking bench for aes_decrypt_core: FIPS-197 vectors, start/abort/
// reset behaviour, latency, and randomized keys/ciphertexts compared with a
// byte-level AES-128 decryption model whose S-boxes are derived from GF(2^8)
// inversion plus the affine transform. Honors `AES_KEY_CACHE_EN.
// -----------------------------------------------------------------------------
module tb_aes_decrypt_core;

`ifdef AES_KEY_CACHE_EN
  localparam bit CACHE_EN = 1'b1;
`else
  localparam bit CACHE_EN = 1'b0;
`endif

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;

  logic clk = 1'b0;
  logic rst_n;
  int   n_tests, n_fail;

  logic [7:0]   m_sbox  [256];
  logic [7:0]   m_isbox [256];
  logic         m_cvld;
  logic [127:0] m_ckey;

  aes_decrypt_core_if bus ();

  aes_decrypt_core #(.N_ROUNDS(10)) dut (
    .CLK    (clk),
    .RESET  (rst_n),
    .aes_if (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  task automatic build_tables();
    logic [7:0] inv, s, xb;
    for (int x = 0; x < 256; x++) begin
      xb  = x[7:0];
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gm(xb, y[7:0]) == 8'h01) inv = y[7:0];
      s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
              ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      m_sbox[x]  = s;
      m_isbox[s] = xb;
    end
  endtask

  function automatic logic [127:0] ref_decrypt(input logic [127:0] key, input logic [127:0] ct);
    logic [31:0]  w [44];
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   rc;
    logic [31:0]  tmp;
    logic [127:0] o;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {m_sbox[tmp[23:16]], m_sbox[tmp[15:8]], m_sbox[tmp[7:0]], m_sbox[tmp[31:24]]}
              ^ {rc, 24'h0};
        rc = gm(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int i = 0; i < 16; i++) s[i] = ct[127-8*i -: 8];
    for (int rnd = 10; rnd >= 0; rnd--) begin
      if (rnd != 10) begin
        for (int i = 0; i < 16; i++) t[i] = s[i];
        for (int c = 0; c < 4; c++)
          for (int r = 0; r < 4; r++)
            s[4*((c+r)%4)+r] = m_isbox[t[4*c+r]];
      end
      for (int i = 0; i < 16; i++) begin
        tmp  = w[4*rnd + i/4];
        s[i] = s[i] ^ tmp[31-8*(i%4) -: 8];
      end
      if (rnd != 0 && rnd != 10) begin
        for (int i = 0; i < 16; i++) t[i] = s[i];
        for (int c = 0; c < 4; c++)
          for (int r = 0; r < 4; r++)
            s[4*c+r] = gm(t[4*c+r], 8'd14) ^ gm(t[4*c+(r+1)%4], 8'd11)
                     ^ gm(t[4*c+(r+2)%4], 8'd13) ^ gm(t[4*c+(r+3)%4], 8'd9);
      end
    end
    o = '0;
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
    return o;
  endfunction

  function automatic int exp_lat(input logic [127:0] key);
    if (CACHE_EN && m_cvld && key == m_ckey) return 40;
    return 50;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Start a run from IDLE and count edges until AES_DONE is seen.
  task automatic do_run(input string tag, input logic [127:0] key, input logic [127:0] ct,
                        input logic [127:0] exp_pt);
    int lat, el;
    el = exp_lat(key);
    bus.AES_KEY     = key;
    bus.AES_MSG_ENC = ct;
    bus.AES_START   = 1'b1;
    @(posedge clk); #1;
    bus.AES_KEY     = rnd128();
    bus.AES_MSG_ENC = rnd128();
    lat = 0;
    while (!bus.AES_DONE && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_lat"}, 128'(lat), 128'(el));
    chk({tag, "_pt"}, bus.AES_MSG_DEC, exp_pt);
    m_cvld = 1'b1;
    m_ckey = key;
  endtask

  task automatic end_run(input string tag, input logic [127:0] exp_pt);
    bus.AES_START = 1'b0;
    @(posedge clk); #1;
    chk({tag, "_drop_done"}, 128'(bus.AES_DONE), 128'(0));
    chk({tag, "_drop_pt"}, bus.AES_MSG_DEC, exp_pt);
  endtask

  initial begin
    logic [127:0] k, c, pt;
    int bad, seen;
    n_tests = 0;
    n_fail  = 0;
    m_cvld  = 1'b0;
    m_ckey  = '0;
    rst_n   = 1'b0;
    bus.AES_START   = 1'b0;
    bus.AES_KEY     = '0;
    bus.AES_MSG_ENC = '0;
    build_tables();

    repeat (3) @(posedge clk);
    #1;
    chk("rst_done", 128'(bus.AES_DONE), 128'(0));
    chk("rst_pt", bus.AES_MSG_DEC, 128'(0));
    #2 rst_n = 1'b1;
    @(posedge clk); #1;

    // FIPS-197 C.1, then hold start high across DONE
    do_run("c1", C1_KEY, C1_CT, C1_PT);
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (bus.AES_DONE !== 1'b1 || bus.AES_MSG_DEC !== C1_PT) bad++;
    end
    chk("hold_bad_cycles", 128'(bad), 128'(0));
    end_run("c1", C1_PT);

    do_run("b", B_KEY, B_CT, B_PT);
    end_run("b", B_PT);

    // Same key twice (cached run is shorter when the cache is built in)
    do_run("c1a", C1_KEY, C1_CT, C1_PT);
    end_run("c1a", C1_PT);
    do_run("c1b", C1_KEY, C1_CT, C1_PT);
    end_run("c1b", C1_PT);
    do_run("b2", B_KEY, B_CT, B_PT);
    end_run("b2", B_PT);

    // Abort: start sampled low at edge 20 of a C.1 run
    bus.AES_KEY     = C1_KEY;
    bus.AES_MSG_ENC = C1_CT;
    bus.AES_START   = 1'b1;
    @(posedge clk);
    repeat (19) @(posedge clk);
    #1 bus.AES_START = 1'b0;
    m_cvld = 1'b1;
    m_ckey = C1_KEY;
    seen = 0;
    bad  = 0;
    for (int i = 0; i < 80; i++) begin
      @(posedge clk); #1;
      if (bus.AES_DONE !== 1'b0) seen++;
      if (bus.AES_MSG_DEC !== B_PT) bad++;
    end
    chk("abort_done_cycles", 128'(seen), 128'(0));
    chk("abort_pt_changed", 128'(bad), 128'(0));

    // Randomized runs, some reusing the previous key
    k = rnd128();
    for (int i = 0; i < 8; i++) begin
      if ($urandom_range(0, 2) != 0) k = rnd128();
      c  = rnd128();
      pt = ref_decrypt(k, c);
      do_run($sformatf("rnd%0d", i), k, c, pt);
      end_run($sformatf("rnd%0d", i), pt);
    end

    // Asynchronous reset between edges, 30 edges into a run
    bus.AES_KEY     = C1_KEY;
    bus.AES_MSG_ENC = C1_CT;
    bus.AES_START   = 1'b1;
    @(posedge clk);
    repeat (30) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst_done", 128'(bus.AES_DONE), 128'(0));
    chk("async_rst_pt", bus.AES_MSG_DEC, 128'(0));
    m_cvld = 1'b0;
    bus.AES_START = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    do_run("c1_after_rst", C1_KEY, C1_CT, C1_PT);
    end_run("c1_after_rst", C1_PT);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
